reed_conditioner: RTL

// - Front end for the wheel reed switch: turns the raw, bouncing contact into the clean one-cycle
//   'reed' strobe that the distance and speed counters consume.
// - Synchronises, debounces and edge-detects the contact, and flags when the wheel has stopped.
// - Optionally measures the clock-cycle period between consecutive strobes for the speed logic.

---
 rtl/reed_conditioner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/reed_conditioner.sv
// Wheel reed-switch front end: 2-FF sync, debounce FSM, one-cycle strobe, motion timeout.
// Define REED_PERIOD_EN to add the strobe-to-strobe period measurement.
module reed_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TIMEOUT_CYCLES  = 4000,
  parameter int PERIOD_W        = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                reed_raw,
  output logic                reed,
  output logic                moving,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OPEN    = 2'd0;
  localparam logic [1:0] CLOSING = 2'd1;
  localparam logic [1:0] CLOSED  = 2'd2;
  localparam logic [1:0] OPENING = 2'd3;

  logic            sync_meta;
  logic            sync;
  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;
  logic            strobe;
  logic [TO_W-1:0] tcnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= reed_raw;
      sync      <= sync_meta;
    end
  end

  // cnt never exceeds DB_LAST: every terminal count forces a state change and a clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strobe  = 1'b0;
    case (state_q)
      OPEN: begin
        if (sync) begin
          state_d = CLOSING;
          cnt_d   = '0;
        end
      end
      CLOSING: begin
        if (!sync) begin
          state_d = OPEN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = CLOSED;
          cnt_d   = '0;
          strobe  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLOSED: begin
        if (!sync) begin
          state_d = OPENING;
          cnt_d   = '0;
        end
      end
      OPENING: begin
        if (sync) begin
          state_d = CLOSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = OPEN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OPEN;
      cnt_q   <= '0;
      reed    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reed    <= strobe;
    end
  end

  // Timeout runs off the registered strobe, so a strobe arriving as the count expires keeps moving high.
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q <= '0;
      moving <= 1'b0;
    end else if (reed) begin
      tcnt_q <= '0;
      moving <= 1'b1;
    end else if (tcnt_q != TO_MAX) begin
      tcnt_q <= tcnt_q + 1'b1;
      if (tcnt_q == TO_LAST) begin
        moving <= 1'b0;
      end
    end
  end

`ifdef REED_PERIOD_EN
  localparam logic [PERIOD_W-1:0] P_MAX = '1;

  logic [PERIOD_W-1:0] pcnt_q;

  // Period is latched on the same edge as reed so period_valid lines up with the strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q       <= '1;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (strobe) begin
      period       <= (pcnt_q == P_MAX) ? P_MAX : pcnt_q + 1'b1;
      period_valid <= 1'b1;
      pcnt_q       <= '0;
    end else begin
      period_valid <= 1'b0;
      if (pcnt_q != P_MAX) begin
        pcnt_q <= pcnt_q + 1'b1;
      end
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
